sync_w2r_ptr: RTL and testbench
===============================

# sync_w2r_ptr

Parametrised write-to-read pointer synchroniser for the asynchronous FIFO, replacing the fixed two-flop chain. It carries the Gray-coded write pointer into the `rclk` domain through a configurable number of flop stages and converts it to binary. It then produces a registered occupancy level, empty flag and update strobe for the read-side control logic. An optional integrity checker flags an impossible level (more than DEPTH entries).

## Interface
- `ADDR_WIDTH`, 3: FIFO address width; pointers are `ADDR_WIDTH+1` bits; DEPTH = 2^ADDR_WIDTH.
- `SYNC_STAGES`, 2: synchroniser flop count; legal range 2..4; elaboration error outside the range.
- `rclk`  in  1: read-domain clock; the only clock.
- `rrst`  in  1: asynchronous, active-high reset.
- `wptr_gray`  in  ADDR_WIDTH+1: Gray write pointer from the `wclk` domain; asynchronous to `rclk`.
- `rptr_bin`  in  ADDR_WIDTH+1: local binary read pointer, already synchronous to `rclk`.
- `rq_wptr_gray`  out  ADDR_WIDTH+1: last synchroniser stage output.
- `rq_wptr_bin`  out  ADDR_WIDTH+1: registered binary form of the synchronised pointer.
- `rlevel`  out  ADDR_WIDTH+1: registered occupancy, `rq_wptr_bin - rptr_bin` modulo 2^(ADDR_WIDTH+1).
- `rempty`  out  1: registered; 1 when the level is 0.
- `rupdate`  out  1: one-cycle pulse when the synchronised binary pointer changes.
- `rerr`  out  1: sticky level-overflow flag; present only with the check macro (see Configuration).

## Operation
- Reset (async assert, released on an `rclk` edge) forces:
  - all synchroniser stages, `rq_wptr_gray`, `rq_wptr_bin`, `rlevel`, `rupdate`, `rerr` to 0;
  - `rempty` to 1.
- Synchroniser: each edge, `s1 <= wptr_gray`, `s(k) <= s(k-1)`. `rq_wptr_gray` = `s(SYNC_STAGES)`. No logic between stages.
- Conversion and level: let b = gray2bin(`s(SYNC_STAGES)`), computed combinationally. Each edge:
  - `rq_wptr_bin <= b`;
  - `rlevel <= b - rptr_bin`, truncated to ADDR_WIDTH+1 bits;
  - `rempty <= (b == rptr_bin)`;
  - `rupdate <= (b != rq_wptr_bin)`.
- Wrap-around: the modulo subtraction handles it. For example, write bin 0 with read bin 15 gives level 1.
- Full state (level == DEPTH) is legal and is not an error.
- Simultaneous change of `rptr_bin` and the synchronised pointer: both values are taken at the same edge. No priority applies.
- Multi-step pointer jumps between samples are legal when `wclk` is faster than `rclk`. No Gray single-bit check is performed.
- Reset mid-operation clears everything within the same cycle (asynchronous). The first post-reset edge samples the live `wptr_gray` again.

## Timing
- Latency from `wptr_gray` change to `rq_wptr_gray`: SYNC_STAGES `rclk` edges (input is sampled at edge 1).
- `rq_wptr_bin`, `rlevel`, `rempty`, `rupdate`: SYNC_STAGES+1 edges after the input change.
- Latency from `rptr_bin` change to `rlevel`/`rempty`: 1 edge.
- `rupdate` is high for exactly one cycle per distinct new synchronised value.
- `rerr` asserts one edge after the offending `rlevel` is registered.

## Configuration
- Macro: `SYNC_W2R_LEVEL_CHECK_EN`.
- Defined:
  - `rerr` is present;
  - it is set when registered `rlevel > DEPTH`;
  - it stays set until `rrst`.
- Undefined:
  - the `rerr` port and its logic are absent;
  - all other behaviour is identical.

## Structure
- Shared package `sync_pkg`:
  - `gray2bin` and `bin2gray` functions, parametrised by width;
  - `SYNC_STAGES_MIN` = 2 and `SYNC_STAGES_MAX` = 4 constants.
- Sub-module `sync_cell`:
  - generic WIDTH × STAGES flop chain with async active-high reset to 0;
  - instantiated once here;
  - reusable for the read-to-write direction.

## Test plan
- Reset check (ADDR_WIDTH=3, SYNC_STAGES=2): assert `rrst` with `wptr_gray`=4'b0111.
  - During reset: all outputs 0, `rempty`=1.
  - After release, `rq_wptr_bin` becomes 5 on the third edge.
- Single write: `wptr_gray` 0000→0001, `rptr_bin`=0.
  - `rq_wptr_gray`=0001 after 2 edges.
  - On edge 3: `rq_wptr_bin`=1, `rlevel`=1, `rempty`=0, `rupdate` pulses for 1 cycle.
- Full and overflow: `rptr_bin`=0.
  - `wptr_gray`=1100 (bin 8) gives `rlevel`=8 and `rerr`=0.
  - Then `wptr_gray`=1101 (bin 9) gives `rlevel`=9, and `rerr`=1 one edge later, which stays set. Run with the macro defined.
- Wrap-around: `rptr_bin`=15.
  - `wptr_gray` 1000 (bin 15) gives `rlevel`=0, `rempty`=1.
  - Then 0000 (bin 0) gives `rlevel`=1, `rempty`=0.
- Stage parameter: with SYNC_STAGES=4, a step on `wptr_gray` appears on `rq_wptr_gray` after exactly 4 edges and on `rlevel` after 5.
- Mid-operation reset and simultaneous events:
  - `rptr_bin` and the synchronised pointer both increment at the same edge: `rlevel` is unchanged and `rupdate`=1.
  - Pulse `rrst` between edges: outputs clear immediately and `rerr` clears.

Source files
------------

// File: rtl/sync_pkg.sv
// Shared helpers for the FIFO pointer synchronisers: Gray/binary conversion
// and the legal range of synchroniser depths.
package sync_pkg;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;

  // Widest pointer the conversion helpers accept; callers zero-extend in and truncate out.
  localparam int SYNC_FN_W = 32;

  function automatic logic [SYNC_FN_W-1:0] width_mask(input int unsigned w);
    logic [SYNC_FN_W-1:0] m;
    if (w >= SYNC_FN_W) begin
      m = '1;
    end else begin
      m = (SYNC_FN_W'(1) << w) - SYNC_FN_W'(1);
    end
    return m;
  endfunction

  // Binary bit i is the XOR of all Gray bits at or above i.
  function automatic logic [SYNC_FN_W-1:0] gray2bin(input logic [SYNC_FN_W-1:0] g,
                                                    input int unsigned           w);
    logic [SYNC_FN_W-1:0] gm;
    logic [SYNC_FN_W-1:0] b;
    gm = g & width_mask(w);
    b  = gm;
    for (int s = 1; s < SYNC_FN_W; s++) begin
      b = b ^ (gm >> s);
    end
    return b;
  endfunction

  function automatic logic [SYNC_FN_W-1:0] bin2gray(input logic [SYNC_FN_W-1:0] b,
                                                    input int unsigned           w);
    logic [SYNC_FN_W-1:0] bm;
    bm = b & width_mask(w);
    return bm ^ (bm >> 1);
  endfunction

endpackage

// File: rtl/sync_cell.sv
// Generic WIDTH x STAGES clock-domain-crossing flop chain, async active-high
// reset to zero. No logic between stages so the tools treat it as a pure synchroniser.
module sync_cell #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < STAGES; k++) begin
        stage_q[k] <= '0;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int k = 1; k < STAGES; k++) begin
        stage_q[k] <= stage_q[k-1];
      end
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/sync_w2r_ptr.sv
// Write-to-read pointer synchroniser: Gray pointer crosses into rclk, is converted
// to binary, and yields registered level/empty/update. Optional: SYNC_W2R_LEVEL_CHECK_EN.
module sync_w2r_ptr
  import sync_pkg::*;
#(
  parameter int ADDR_WIDTH  = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic [ADDR_WIDTH:0] wptr_gray,
  input  logic [ADDR_WIDTH:0] rptr_bin,
  output logic [ADDR_WIDTH:0] rq_wptr_gray,
  output logic [ADDR_WIDTH:0] rq_wptr_bin,
  output logic [ADDR_WIDTH:0] rlevel,
  output logic                rempty,
  output logic                rupdate
`ifdef SYNC_W2R_LEVEL_CHECK_EN
  ,
  output logic                rerr
`endif
);

  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
    $error("sync_w2r_ptr: SYNC_STAGES must lie in 2..4");
  end

  logic [PW-1:0] sync_gray;
  logic [PW-1:0] bin_d;
  logic [PW-1:0] level_d;
  logic          empty_d;
  logic          update_d;

  logic [PW-1:0] bin_q;
  logic [PW-1:0] level_q;
  logic          empty_q;
  logic          update_q;

  // Stage chain: wptr_gray -> s1 .. s(SYNC_STAGES)
  sync_cell #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i (rclk),
    .rst_i (rrst),
    .d_i   (wptr_gray),
    .q_o   (sync_gray)
  );

  // Conversion/level boundary: combinational from last stage, registered below
  always_comb begin
    bin_d    = PW'(gray2bin(SYNC_FN_W'(sync_gray), PW));
    level_d  = bin_d - rptr_bin;
    empty_d  = (bin_d == rptr_bin);
    update_d = (bin_d != bin_q);
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      bin_q    <= '0;
      level_q  <= '0;
      empty_q  <= 1'b1;
      update_q <= 1'b0;
    end else begin
      bin_q    <= bin_d;
      level_q  <= level_d;
      empty_q  <= empty_d;
      update_q <= update_d;
    end
  end

  assign rq_wptr_gray = sync_gray;
  assign rq_wptr_bin  = bin_q;
  assign rlevel       = level_q;
  assign rempty       = empty_q;
  assign rupdate      = update_q;

`ifdef SYNC_W2R_LEVEL_CHECK_EN
  logic err_d;
  logic err_q;

  // Check boundary: judges the already-registered level; exactly DEPTH means full, not error
  assign err_d = err_q | (level_q > PW'(DEPTH));

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign rerr = err_q;
`endif

endmodule

// File: tb/tb_sync_w2r_ptr.sv
// Self-checking bench for sync_w2r_ptr: SYNC_STAGES=2 and 4 instances side by side,
// directed table, hand-written corner sequences and randomized traffic against a history model.
module tb_sync_w2r_ptr;

  localparam int AW = 3;
  localparam int PW = AW + 1;
  localparam int DEPTH = 1 << AW;
  localparam int MODV = 1 << PW;

  logic          rclk = 1'b0;
  logic          rrst;
  logic [PW-1:0] wptr_gray;
  logic [PW-1:0] rptr_bin;

  logic [PW-1:0] g2, b2, l2, g4, b4, l4;
  logic          e2, u2, e4, u4;
`ifdef SYNC_W2R_LEVEL_CHECK_EN
  logic          x2, x4;
`endif

  sync_w2r_ptr #(.ADDR_WIDTH(AW), .SYNC_STAGES(2)) dut2 (
    .rclk(rclk), .rrst(rrst), .wptr_gray(wptr_gray), .rptr_bin(rptr_bin),
    .rq_wptr_gray(g2), .rq_wptr_bin(b2), .rlevel(l2), .rempty(e2), .rupdate(u2)
`ifdef SYNC_W2R_LEVEL_CHECK_EN
    , .rerr(x2)
`endif
  );

  sync_w2r_ptr #(.ADDR_WIDTH(AW), .SYNC_STAGES(4)) dut4 (
    .rclk(rclk), .rrst(rrst), .wptr_gray(wptr_gray), .rptr_bin(rptr_bin),
    .rq_wptr_gray(g4), .rq_wptr_bin(b4), .rlevel(l4), .rempty(e4), .rupdate(u4)
`ifdef SYNC_W2R_LEVEL_CHECK_EN
    , .rerr(x4)
`endif
  );

  always #5 rclk = ~rclk;

  int tests = 0;
  int fails = 0;

  // Model state: every sampled input since the last reset, plus sticky error per instance
  int wh[$];
  int rh[$];
  bit err_m [2];

  typedef struct {
    logic [3:0] w, r, eg, eb, el;
    logic       ee, eu, ex;
  } vec_t;
  vec_t tbl [17];

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int g2b(input int g);
    for (int b = 0; b < MODV; b++) begin
      if ((b ^ (b >> 1)) == g) return b;
    end
    return -1;
  endfunction

  function automatic int w_at(input int k);
    return (k < 0) ? 0 : wh[k];
  endfunction

  task automatic model_clear();
    wh.delete();
    rh.delete();
    err_m[0] = 1'b0;
    err_m[1] = 1'b0;
  endtask

  task automatic model_chk(input int s, input int si, input int ag, input int ab,
                           input int al, input int ae, input int au, input int ax);
    int n, eg, eb, el, ex;
    bit ee, eu;
    n  = wh.size();
    eg = w_at(n - s);
    eb = g2b(w_at(n - s - 1));
    el = (eb - rh[n-1] + MODV) % MODV;
    ee = (el == 0);
    eu = (eb != g2b(w_at(n - s - 2)));
    ex = err_m[si];
    if (el > DEPTH) err_m[si] = 1'b1;
    chk($sformatf("model S%0d gray", s), ag, eg);
    chk($sformatf("model S%0d bin", s), ab, eb);
    chk($sformatf("model S%0d level", s), al, el);
    chk($sformatf("model S%0d empty", s), ae, int'(ee));
    chk($sformatf("model S%0d update", s), au, int'(eu));
`ifdef SYNC_W2R_LEVEL_CHECK_EN
    chk($sformatf("model S%0d err", s), ax, ex);
`endif
  endtask

  task automatic edge_step();
    int ax2, ax4;
    @(posedge rclk);
    wh.push_back(int'(wptr_gray));
    rh.push_back(int'(rptr_bin));
    #1;
    ax2 = 0; ax4 = 0;
`ifdef SYNC_W2R_LEVEL_CHECK_EN
    ax2 = int'(x2); ax4 = int'(x4);
`endif
    model_chk(2, 0, g2, b2, l2, e2, u2, ax2);
    model_chk(4, 1, g4, b4, l4, e4, u4, ax4);
  endtask

  task automatic chk_cleared(input string nm);
    chk({nm, " gray2"}, g2, 0);  chk({nm, " bin2"}, b2, 0);  chk({nm, " lvl2"}, l2, 0);
    chk({nm, " empty2"}, e2, 1); chk({nm, " upd2"}, u2, 0);
    chk({nm, " gray4"}, g4, 0);  chk({nm, " lvl4"}, l4, 0);  chk({nm, " empty4"}, e4, 1);
`ifdef SYNC_W2R_LEVEL_CHECK_EN
    chk({nm, " err2"}, x2, 0);   chk({nm, " err4"}, x4, 0);
`endif
  endtask

  task automatic do_reset(input logic [PW-1:0] w, input logic [PW-1:0] r);
    wptr_gray = w;
    rptr_bin  = r;
    rrst = 1'b1;
    #1;
    chk_cleared("reset");
    repeat (2) @(posedge rclk);
    @(negedge rclk);
    rrst = 1'b0;
    model_clear();
  endtask

  initial begin
    int wb, rb;
    tbl[0]  = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{4'h1, 4'h0, 4'h1, 4'h1, 4'h1, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{4'h1, 4'h0, 4'h1, 4'h1, 4'h1, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{4'hC, 4'h0, 4'h1, 4'h1, 4'h1, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{4'hC, 4'h0, 4'hC, 4'h1, 4'h1, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{4'hC, 4'h0, 4'hC, 4'h8, 4'h8, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{4'hD, 4'h0, 4'hC, 4'h8, 4'h8, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{4'hD, 4'h0, 4'hD, 4'h8, 4'h8, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{4'hD, 4'h0, 4'hD, 4'h9, 4'h9, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{4'hD, 4'h0, 4'hD, 4'h9, 4'h9, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{4'h8, 4'hF, 4'hD, 4'h9, 4'hA, 1'b0, 1'b0, 1'b1};
    tbl[12] = '{4'h8, 4'hF, 4'h8, 4'h9, 4'hA, 1'b0, 1'b0, 1'b1};
    tbl[13] = '{4'h8, 4'hF, 4'h8, 4'hF, 4'h0, 1'b1, 1'b1, 1'b1};
    tbl[14] = '{4'h0, 4'hF, 4'h8, 4'hF, 4'h0, 1'b1, 1'b0, 1'b1};
    tbl[15] = '{4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 1'b1, 1'b0, 1'b1};
    tbl[16] = '{4'h0, 4'hF, 4'h0, 4'h0, 4'h1, 1'b0, 1'b1, 1'b1};

    // Reset with a live pointer of Gray 0111 (binary 5)
    do_reset(4'b0111, 4'h0);
    edge_step();
    chk("rst edge1 bin", b2, 0);
    edge_step();
    chk("rst edge2 gray", g2, 4'b0111);
    chk("rst edge2 bin", b2, 0);
    edge_step();
    chk("rst edge3 bin", b2, 5);

    // Directed table: single write, full, overflow, wrap-around
    do_reset(4'h0, 4'h0);
    for (int i = 0; i < 17; i++) begin
      wptr_gray = tbl[i].w;
      rptr_bin  = tbl[i].r;
      edge_step();
      chk($sformatf("tbl%0d gray", i), g2, tbl[i].eg);
      chk($sformatf("tbl%0d bin", i), b2, tbl[i].eb);
      chk($sformatf("tbl%0d level", i), l2, tbl[i].el);
      chk($sformatf("tbl%0d empty", i), e2, tbl[i].ee);
      chk($sformatf("tbl%0d update", i), u2, tbl[i].eu);
`ifdef SYNC_W2R_LEVEL_CHECK_EN
      chk($sformatf("tbl%0d err", i), x2, tbl[i].ex);
`endif
    end

    // Read and synchronised write pointer advance on the same edge
    rptr_bin = 4'h0;
    edge_step();
    edge_step();
    chk("simul pre level", l2, 0);
    wptr_gray = 4'b0001;
    edge_step();
    edge_step();
    chk("simul mid level", l2, 0);
    rptr_bin = 4'h1;
    edge_step();
    chk("simul level", l2, 0);
    chk("simul update", u2, 1);
    chk("simul empty", e2, 1);
    chk("simul bin", b2, 1);

    // Reset pulse between edges clears everything at once
    #2 rrst = 1'b1;
    #1;
    chk_cleared("pulse");
    #1 rrst = 1'b0;
    model_clear();

    // Four-stage latency: gray after 4 edges, level after 5
    wptr_gray = 4'b0010;
    rptr_bin  = 4'h3;
    repeat (6) edge_step();
    wptr_gray = 4'b0110;
    for (int e = 1; e <= 5; e++) begin
      edge_step();
      chk($sformatf("s4 edge%0d gray", e), g4, (e >= 4) ? 4'b0110 : 4'b0010);
      chk($sformatf("s4 edge%0d level", e), l4, (e >= 5) ? 1 : 0);
    end

    // Randomized traffic against the history model
    wb = 4;
    rb = 3;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) == 0) wb = (wb + int'($urandom_range(1, 3))) % MODV;
      if ($urandom_range(0, 2) == 0) rb = (rb + int'($urandom_range(0, 2))) % MODV;
      wptr_gray = PW'(wb ^ (wb >> 1));
      rptr_bin  = PW'(rb);
      edge_step();
      if (i == 150) begin
        #2 rrst = 1'b1;
        #1;
        chk_cleared("rand pulse");
        #1 rrst = 1'b0;
        model_clear();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
